uart_tx_fifo: RTL and testbench

Transmit FIFO of the UART, directly upstream of `transmitter`. It buffers characters written by the processor interface and presents them to the transmitter on the `fifo_data` / `fifo_data_valid` / `fifo_data_taken` handshake. It also produces the TX status flags (full, empty, busy) and the level-triggered TX interrupt request. Single clock domain (UARTCLK).

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit FIFO feeding the UART transmitter. Buffers characters written by
// the register interface, presents the head character with a show-ahead
// valid/taken handshake, and derives the TX status flags and the
// level-triggered TX interrupt request. Single clock domain (UARTCLK).

module uart_tx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     fifo_en,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [2:0]               tx_ifls,
    input  logic                     tx_fifo_busy,
    output logic [DATA_W-1:0]        fifo_data,
    output logic                     fifo_data_valid,
    input  logic                     fifo_data_taken,
    output logic                     full,
    output logic                     empty,
    output logic                     uart_busy,
    output logic                     wr_drop,
    output logic                     txint_req,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] CAP_FIFO = CW'(DEPTH);
    localparam logic [CW-1:0] CAP_HOLD = CW'(1);

    localparam logic [CW-1:0] THR_1_8 = CW'(DEPTH / 8);
    localparam logic [CW-1:0] THR_1_4 = CW'(DEPTH / 4);
    localparam logic [CW-1:0] THR_1_2 = CW'(DEPTH / 2);
    localparam logic [CW-1:0] THR_3_4 = CW'((3 * DEPTH) / 4);
    localparam logic [CW-1:0] THR_7_8 = CW'((7 * DEPTH) / 8);

    // UARTIFLS TXIFLSEL encodings; remaining codes fall back to half full
    typedef enum logic [2:0] {
        IFLS_1_8 = 3'b000,
        IFLS_1_4 = 3'b001,
        IFLS_1_2 = 3'b010,
        IFLS_3_4 = 3'b011,
        IFLS_7_8 = 3'b100
    } ifls_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              fen_q;
    logic              wr_drop_q;

    logic [CW-1:0]     cap;
    logic [CW-1:0]     thr;
    logic              flush_all;
    logic              wr_ok;
    logic              take_ok;
    logic              drop_now;

    // Effective capacity, flags and accept/flush qualification from the
    // pre-edge count; flush (explicit or mode change) overrides everything
    always_comb begin
        cap       = fifo_en ? CAP_FIFO : CAP_HOLD;
        full      = (count == cap);
        empty     = (count == '0);
        flush_all = flush | (fifo_en ^ fen_q);
        wr_ok     = wr_en & ~full & ~flush_all;
        take_ok   = fifo_data_taken & ~empty & ~flush_all;
        drop_now  = wr_en & full & ~flush_all;
    end

    // Interrupt threshold decode
    always_comb begin
        thr = THR_1_2;
        case (ifls_e'(tx_ifls))
            IFLS_1_8: thr = THR_1_8;
            IFLS_1_4: thr = THR_1_4;
            IFLS_1_2: thr = THR_1_2;
            IFLS_3_4: thr = THR_3_4;
            IFLS_7_8: thr = THR_7_8;
            default:  thr = THR_1_2;
        endcase
    end

    // Head presentation, busy and interrupt request
    always_comb begin
        fifo_data_valid = ~empty;
        fifo_data       = fifo_data_valid ? mem[rd_ptr] : '0;
        uart_busy       = ~empty | tx_fifo_busy;
        txint_req       = fifo_en ? (count <= thr) : empty;
        wr_drop         = wr_drop_q;
    end

    // Pointer, occupancy and mode-tracking state
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fen_q     <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            fen_q     <= fifo_en;
            wr_drop_q <= drop_now;
            if (flush_all) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (take_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({wr_ok, take_ok})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Character storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed and randomized checks of uart_tx_fifo against a queue-based
// reference model of the FIFO behaviour.

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          fifo_en;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [2:0]    tx_ifls;
    logic          tx_fifo_busy;
    logic [DW-1:0] fifo_data;
    logic          fifo_data_valid;
    logic          fifo_data_taken;
    logic          full;
    logic          empty;
    logic          uart_busy;
    logic          wr_drop;
    logic          txint_req;
    logic [4:0]    count;

    always #5 CLK = ~CLK;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .fifo_en         (fifo_en),
        .flush           (flush),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .tx_ifls         (tx_ifls),
        .tx_fifo_busy    (tx_fifo_busy),
        .fifo_data       (fifo_data),
        .fifo_data_valid (fifo_data_valid),
        .fifo_data_taken (fifo_data_taken),
        .full            (full),
        .empty           (empty),
        .uart_busy       (uart_busy),
        .wr_drop         (wr_drop),
        .txint_req       (txint_req),
        .count           (count)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic          m_fen_q;
    logic          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_thr(input logic [2:0] sel);
        case (sel)
            3'd0:    return DEPTH / 8;
            3'd1:    return DEPTH / 4;
            3'd3:    return (3 * DEPTH) / 4;
            3'd4:    return (7 * DEPTH) / 8;
            default: return DEPTH / 2;
        endcase
    endfunction

    function automatic int m_cap(input logic fen);
        return fen ? DEPTH : 1;
    endfunction

    // Advance the model by one clock edge using the inputs sampled there
    task automatic model_edge();
        int  n;
        int  cap;
        bit  fl;
        bit  wok;
        bit  tok;
        n   = mq.size();
        cap = m_cap(fifo_en);
        fl  = flush || (fifo_en != m_fen_q);
        wok = wr_en && (n < cap);
        tok = fifo_data_taken && (n > 0);
        m_fen_q = fifo_en;
        if (fl) begin
            mq.delete();
            m_drop = 1'b0;
        end else begin
            m_drop = wr_en && (n >= cap);
            if (tok) void'(mq.pop_front());
            if (wok) mq.push_back(wr_data);
        end
    endtask

    task automatic check_model();
        int      n;
        logic [DW-1:0] head;
        n    = mq.size();
        head = (n > 0) ? mq[0] : '0;
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == m_cap(fifo_en)));
        check("empty", 32'(empty), 32'(n == 0));
        check("valid", 32'(fifo_data_valid), 32'(n != 0));
        check("data", 32'(fifo_data), 32'(head));
        check("busy", 32'(uart_busy), 32'((n != 0) || tx_fifo_busy));
        check("drop", 32'(wr_drop), 32'(m_drop));
        check("txint", 32'(txint_req),
              32'(fifo_en ? (n <= m_thr(tx_ifls)) : (n == 0)));
    endtask

    // One clock: apply inputs, take the edge, update model, compare
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic t, input logic f);
        wr_en           = w;
        wr_data         = d;
        fifo_data_taken = t;
        flush           = f;
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [DW-1:0] ord [4];

    initial begin
        RSTn            = 1'b0;
        fifo_en         = 1'b1;
        flush           = 1'b0;
        wr_en           = 1'b0;
        wr_data         = '0;
        tx_ifls         = 3'b010;
        tx_fifo_busy    = 1'b0;
        fifo_data_taken = 1'b0;
        mq.delete();
        m_fen_q = 1'b0;
        m_drop  = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(fifo_data_valid), 32'd0);
        check("rst_data", 32'(fifo_data), 32'h00);
        check("rst_txint", 32'(txint_req), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_drop", 32'(wr_drop), 32'd0);
        check_model();
        RSTn = 1'b1;
        idle();
        idle();

        // Ordering
        ord[0] = 8'hAA; ord[1] = 8'h55; ord[2] = 8'h80; ord[3] = 8'h02;
        for (int i = 0; i < 4; i++) cycle(1'b1, ord[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ord_head", 32'(fifo_data), 32'(ord[i]));
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check("ord_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain across pointer wrap
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_drop", 32'(wr_drop), 32'd1);
        check("ovf_head", 32'(fifo_data), 32'h00);
        for (int i = 0; i < 16; i++) begin
            check("drain_head", 32'(fifo_data), 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Simultaneous write and take
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        check("wt5_count", 32'(count), 32'd5);
        check("wt5_head", 32'(fifo_data), 32'h11);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("wte_count", 32'(count), 32'd1);
        check("wte_head", 32'(fifo_data), 32'h3C);
        idle();
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        check("wtf_count", 32'(count), 32'd15);
        check("wtf_drop", 32'(wr_drop), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'd0);

        // Holding-register mode
        fifo_en = 1'b0;
        idle();
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        check("hold_full", 32'(full), 32'd1);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        check("hold_drop", 32'(wr_drop), 32'd1);
        check("hold_head", 32'(fifo_data), 32'h11);
        fifo_en = 1'b1;
        idle();
        check("toggle_empty", 32'(empty), 32'd1);
        fifo_en = 1'b0;
        idle();
        tx_fifo_busy = 1'b1;
        #1;
        check("busy_tx", 32'(uart_busy), 32'd1);
        tx_fifo_busy = 1'b0;

        // Interrupt levels and flush priority
        fifo_en = 1'b1;
        idle();
        tx_ifls = 3'b010;
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        check("int_half_8", 32'(txint_req), 32'd1);
        cycle(1'b1, 8'h08, 1'b0, 1'b0);
        check("int_half_9", 32'(txint_req), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        tx_ifls = 3'b000;
        for (int i = 0; i < 2; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        check("int_8th_2", 32'(txint_req), 32'd1);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        check("int_8th_3", 32'(txint_req), 32'd0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        check("flushwr_count", 32'(count), 32'd0);
        check("flushwr_drop", 32'(wr_drop), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int pw;
            if ($urandom_range(63) == 0) fifo_en = ~fifo_en;
            if ((i % 50) == 0) tx_ifls = 3'($urandom_range(7));
            tx_fifo_busy = 1'($urandom_range(1));
            pw = ((i / 200) % 2 == 1) ? 80 : 30;
            cycle(1'($urandom_range(99) < pw), DW'($urandom_range(255)),
                  1'($urandom_range(99) >= pw), 1'($urandom_range(49) == 0));
        end

        // Reset mid-operation drops contents immediately
        fifo_en = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        RSTn = 1'b0;
        #1;
        check("arst_valid", 32'(fifo_data_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_data", 32'(fifo_data), 32'h00);
        mq.delete();
        m_fen_q = 1'b0;
        m_drop  = 1'b0;
        check_model();
        #3;
        RSTn = 1'b1;
        idle();
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        check("post_rst_head", 32'(fifo_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
